map_scanner: RTL
================

Name: map_scanner

Overview:
- Reader side of the track-map ROM interface.
- Walks the 5-lane track row by row on each scroll tick.
- For each row it issues (lane, row) addresses, captures the 3-bit cell states, and packs a VIEW-row window for the renderer.
- After every refresh it reports hit/coin events for the player's current lane. Sits between the map ROM and the display/game-logic blocks.

Parameters:
- LANES, 5, lanes per row (map index_x range 0..LANES-1).
- VIEW, 8, rows buffered ahead of the player (row 0 = player row).
- Y_W, 7, width of row address driven to the map (zero-extended at top level).
- RD_LAT, 1, map read latency in clk cycles (state valid RD_LAT cycles after address).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse: reset position to row 0 and begin a refresh.
- tick  in  1  pulse: advance one row and refresh the window.
- player_lane  in  3  player lane, 0..LANES-1; sampled when the refresh completes.
- map_len  in  11  track length in rows, from the map.
- map_state  in  3  cell state returned by the map: 0 empty, 1 wall, 2 coin.
- index_x  out  3  lane address to the map.
- index_y  out  Y_W  row address to the map.
- view_cells  out  VIEW*LANES*3  packed window; cell (r, l) at bits [(r*LANES+l)*3 +: 3].
- pos  out  11  current player row.
- busy  out  1  high while a refresh is in progress.
- view_valid  out  1  one-cycle pulse when view_cells is updated.
- hit  out  1  one-cycle pulse with view_valid when cell (0, player_lane) == 1.
- coin  out  1  one-cycle pulse with view_valid when cell (0, player_lane) == 2.
- end_of_map  out  1  sticky; set when pos reaches map_len-1.
- overrun  out  1  sticky; set when a tick is dropped.

Behaviour:
Reset (rst=1 at a clk edge) forces the following. Reset mid-refresh aborts the refresh; partial data is discarded.
- FSM = IDLE; pos = 0.
- view_cells = 0; index_x = 0; index_y = 0.
- All pulse outputs, busy, end_of_map, overrun = 0.
- Pending-tick flag cleared.

FSM states: IDLE, ISSUE, DRAIN, COMMIT.
- IDLE:
  - start → pos=0, clear end_of_map and overrun, go to ISSUE.
  - tick with end_of_map=0 → pos+1, then ISSUE.
  - tick with end_of_map=1 → ignored; no refresh.
- ISSUE:
  - Issues one address per cycle, lane-major inside a row: (r=0, l=0..LANES-1), then r=1, and so on. Total VIEW*LANES cycles.
  - index_y = pos + r.
- DRAIN: waits RD_LAT cycles for the last data.
- COMMIT (1 cycle):
  - Copies the shadow buffer to view_cells.
  - Pulses view_valid, plus hit/coin.
  - Sets end_of_map if pos == map_len-1.
  - Returns to IDLE, or to ISSUE if a tick is pending. A pending tick advances pos at the moment of that transition.
- Refresh latency: from the cycle after start/tick to view_valid is VIEW*LANES + RD_LAT + 1 cycles (42 at defaults).

Capture:
- map_state is written into a shadow buffer RD_LAT cycles after its address, using a delayed copy of (r, l).
- view_cells never shows a partial window.

Boundary handling:
- Row overrun: if pos + r >= map_len, the cell is forced to 0 and index_y is held at map_len-1. Rows past the end read as empty.
- Tick while busy: set the pending flag (one deep). A further tick while pending is dropped and sets overrun.
- start while busy: restarts immediately (pos=0, ISSUE from r=0,l=0); clears pending.
- start and tick in the same cycle: start wins.
- player_lane >= LANES: hit = coin = 0.
- pos saturates at map_len-1; never wraps.
- Arithmetic: pos + r is computed at 11 bits; index_y is the low Y_W bits.

Decomposition:
- Package map_pkg holds:
  - cell enum: CELL_EMPTY=0, CELL_WALL=1, CELL_COIN=2.
  - Constants LANES_DEF=5, VIEW_DEF=8.
  - FSM state typedef.
- One sub-module, map_addr_gen: the (r, l) counter pair with row-overrun clamp; outputs addr, last_flag, and a delayed capture index.

Test Plan:
- Bench ROM (RD_LAT=1, map_len=20), cell(y,x) = (y+x)%3. Pulse start → busy for 42 cycles, view_valid once. view_cells cell(2,1) = 0, cell(0,2) = 2.
- player_lane=1, row 0 lane 1 = 1 (wall). start → hit pulses with view_valid, coin=0. Set lane 2 (coin) → coin=1, hit=0.
- After the first refresh, 18 ticks each spaced 50 cycles → pos=18, end_of_map=0.
  - A 19th tick → pos=19; rows 20..26 of the window read all-zero; end_of_map=1.
  - Further tick → no refresh, no view_valid.
- Three ticks at cycles 5, 6, 7 of a refresh → one pending, overrun=1. Exactly two view_valid pulses total; final pos=1 (start, then one pending tick).
- Assert rst at cycle 20 of a refresh → next cycle busy=0, view_cells=0, pos=0, no view_valid. Then start → normal refresh.
- start and tick in the same cycle with pos=5 → pos=0, overrun cleared, single refresh.

Source files
------------

// File: rtl/map_pkg.sv
// map_pkg: shared types and constants for the track-map scanner.
//   - cell_e  : 3-bit cell codes returned by the map ROM
//   - state_t : scanner FSM state encoding (IDLE/ISSUE/DRAIN/COMMIT)
//   - LANES_DEF / VIEW_DEF : default window geometry
package map_pkg;

  localparam int LANES_DEF = 5;
  localparam int VIEW_DEF  = 8;
  localparam int CELL_W    = 3;
  localparam int POS_W     = 11;

  typedef enum logic [2:0] {
    CELL_EMPTY = 3'd0,
    CELL_WALL  = 3'd1,
    CELL_COIN  = 3'd2
  } cell_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ISSUE  = 2'd1;
  localparam state_t ST_DRAIN  = 2'd2;
  localparam state_t ST_COMMIT = 2'd3;

endpackage

// File: rtl/map_addr_gen.sv
// map_addr_gen: (row, lane) address walker for one window refresh.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clear         : restart the walk at (0,0) and flush in-flight captures
//   advance       : present the current address this cycle and step to the next
//   pos, map_len  : window base row and track length
//   index_x/y     : address to the map ROM (zero when not advancing)
//   last_flag     : current address is the final (VIEW-1, LANES-1) cell
//   cap_*         : (row, lane) delayed by RD_LAT, aligned with map_state;
//                   cap_zero marks a row past the end of the track
module map_addr_gen
  import map_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int VIEW   = VIEW_DEF,
  parameter int Y_W    = 7,
  parameter int RD_LAT = 1,
  localparam int RW    = (VIEW > 1) ? $clog2(VIEW) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [POS_W-1:0] pos,
  input  logic [POS_W-1:0] map_len,
  output logic [2:0]       index_x,
  output logic [Y_W-1:0]   index_y,
  output logic             last_flag,
  output logic             cap_valid,
  output logic             cap_zero,
  output logic [RW-1:0]    cap_row,
  output logic [2:0]       cap_lane
);

  localparam logic [2:0]    LANE_MAX = 3'(LANES - 1);
  localparam logic [RW-1:0] ROW_MAX  = RW'(VIEW - 1);

  typedef struct packed {
    logic          valid;
    logic          zero;
    logic [RW-1:0] row;
    logic [2:0]    lane;
  } cap_t;

  logic [2:0]       lane_q, lane_d;
  logic [RW-1:0]    row_q, row_d;
  logic [POS_W-1:0] row_sum, y_clamp, y_full;
  logic             past_end;
  cap_t             cap_q [RD_LAT];
  cap_t             cap_d [RD_LAT];

  // Lane-major walk: all lanes of a row, then the next row; wraps to (0,0)
  // after the last cell so the next refresh starts clean.
  always_comb begin
    lane_d = lane_q;
    row_d  = row_q;
    if (clear) begin
      lane_d = '0;
      row_d  = '0;
    end else if (advance) begin
      if (lane_q == LANE_MAX) begin
        lane_d = '0;
        row_d  = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
      end else begin
        lane_d = lane_q + 3'd1;
      end
    end
  end

  // Rows beyond the track read as empty; the address is clamped to the last
  // real row so the ROM never sees an out-of-range index.
  assign row_sum   = pos + POS_W'(row_q);
  assign past_end  = (row_sum >= map_len);
  assign y_clamp   = map_len - POS_W'(1);
  assign y_full    = past_end ? y_clamp : row_sum;
  assign index_x   = advance ? lane_q : 3'd0;
  assign index_y   = advance ? Y_W'(y_full) : '0;
  assign last_flag = (lane_q == LANE_MAX) && (row_q == ROW_MAX);

  // Capture-index delay line, matched to the ROM read latency.
  always_comb begin
    cap_d[0].valid = advance & ~clear;
    cap_d[0].zero  = past_end;
    cap_d[0].row   = row_q;
    cap_d[0].lane  = lane_q;
    for (int i = 1; i < RD_LAT; i++) begin
      cap_d[i] = cap_q[i-1];
    end
    if (clear) begin
      for (int i = 0; i < RD_LAT; i++) begin
        cap_d[i].valid = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      row_q  <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        cap_q[i] <= '0;
      end
    end else begin
      lane_q <= lane_d;
      row_q  <= row_d;
      for (int i = 0; i < RD_LAT; i++) begin
        cap_q[i] <= cap_d[i];
      end
    end
  end

  assign cap_valid = cap_q[RD_LAT-1].valid;
  assign cap_zero  = cap_q[RD_LAT-1].zero;
  assign cap_row   = cap_q[RD_LAT-1].row;
  assign cap_lane  = cap_q[RD_LAT-1].lane;

endmodule

// File: rtl/map_scanner.sv
// map_scanner: reads a VIEW-row window of the track map on each start/tick
// and publishes it atomically to the renderer, with hit/coin events for the
// player's lane.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, tick         : single-cycle command pulses (start has priority)
//   player_lane         : lane used for hit/coin, sampled at commit
//   map_len             : track length in rows
//   map_state           : ROM cell data, valid RD_LAT cycles after address
//   index_x, index_y    : ROM address
//   view_cells          : packed window, cell (r,l) at [(r*LANES+l)*3 +: 3]
//   pos                 : current player row
//   busy                : refresh in progress
//   view_valid/hit/coin : one-cycle pulses when view_cells updates
//   end_of_map, overrun : sticky status flags
//   dbg_state           : FSM state for observation
// Interface contract: start/tick are fire-and-forget pulses with no ready;
// a tick arriving while busy is queued one deep, and any further tick while
// one is queued is dropped and flagged in overrun. view_valid marks the one
// cycle in which view_cells, hit and coin carry a fresh, complete window.
module map_scanner
  import map_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int VIEW   = VIEW_DEF,
  parameter int Y_W    = 7,
  parameter int RD_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        tick,
  input  logic [2:0]                  player_lane,
  input  logic [POS_W-1:0]            map_len,
  input  logic [2:0]                  map_state,
  output logic [2:0]                  index_x,
  output logic [Y_W-1:0]              index_y,
  output logic [VIEW*LANES*CELL_W-1:0] view_cells,
  output logic [POS_W-1:0]            pos,
  output logic                        busy,
  output logic                        view_valid,
  output logic                        hit,
  output logic                        coin,
  output logic                        end_of_map,
  output logic                        overrun,
  output state_t                      dbg_state
);

  localparam int WIN_W = VIEW * LANES * CELL_W;
  localparam int RW    = (VIEW > 1) ? $clog2(VIEW) : 1;
  localparam int DW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [DW-1:0] DRAIN_MAX = DW'(RD_LAT - 1);

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             pend_q, pend_d;
  logic             eom_q, eom_d;
  logic             ovr_q, ovr_d;
  logic             vv_q, vv_d;
  logic             hit_q, hit_d;
  logic             coin_q, coin_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [WIN_W-1:0] view_q, view_d;
  logic [WIN_W-1:0] shadow_q, shadow_d;

  logic             gen_clear, gen_adv, last_flag;
  logic             cap_valid, cap_zero;
  logic [RW-1:0]    cap_row;
  logic [2:0]       cap_lane;
  logic [POS_W-1:0] pos_last, pos_inc;
  logic             lane_ok, eom_set;
  logic [CELL_W-1:0] cell0;

  map_addr_gen #(
    .LANES  (LANES),
    .VIEW   (VIEW),
    .Y_W    (Y_W),
    .RD_LAT (RD_LAT)
  ) u_addr (
    .clk       (clk),
    .rst       (rst),
    .clear     (gen_clear),
    .advance   (gen_adv),
    .pos       (pos_q),
    .map_len   (map_len),
    .index_x   (index_x),
    .index_y   (index_y),
    .last_flag (last_flag),
    .cap_valid (cap_valid),
    .cap_zero  (cap_zero),
    .cap_row   (cap_row),
    .cap_lane  (cap_lane)
  );

  // pos never moves past the last row of the track.
  assign pos_last = map_len - POS_W'(1);
  assign pos_inc  = (pos_q >= pos_last) ? pos_last : pos_q + POS_W'(1);

  always_comb begin
    cell0   = '0;
    lane_ok = (int'(player_lane) < LANES);
    if (lane_ok) begin
      cell0 = shadow_q[int'(player_lane)*CELL_W +: CELL_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    pend_d    = pend_q;
    eom_d     = eom_q;
    ovr_d     = ovr_q;
    view_d    = view_q;
    vv_d      = 1'b0;
    hit_d     = 1'b0;
    coin_d    = 1'b0;
    drain_d   = drain_q;
    gen_clear = 1'b0;
    gen_adv   = 1'b0;
    eom_set   = 1'b0;
    if (start) begin
      // Restart from any state; an in-flight refresh is abandoned.
      pos_d     = '0;
      pend_d    = 1'b0;
      eom_d     = 1'b0;
      ovr_d     = 1'b0;
      drain_d   = '0;
      gen_clear = 1'b1;
      state_d   = ST_ISSUE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick && !eom_q) begin
            pos_d   = pos_inc;
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          gen_adv = 1'b1;
          if (tick) begin
            if (pend_q) ovr_d  = 1'b1;
            else        pend_d = 1'b1;
          end
          if (last_flag) begin
            drain_d = '0;
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (tick) begin
            if (pend_q) ovr_d  = 1'b1;
            else        pend_d = 1'b1;
          end
          if (drain_q == DRAIN_MAX) state_d = ST_COMMIT;
          else                      drain_d = drain_q + DW'(1);
        end
        ST_COMMIT: begin
          view_d  = shadow_q;
          vv_d    = 1'b1;
          hit_d   = lane_ok && (cell0 == CELL_WALL);
          coin_d  = lane_ok && (cell0 == CELL_COIN);
          eom_set = (pos_q == pos_last);
          eom_d   = eom_q | eom_set;
          pend_d  = 1'b0;
          // A tick landing in this cycle counts as queued; if one was
          // already queued, the newcomer is the dropped one.
          if (tick && pend_q) ovr_d = 1'b1;
          if ((pend_q || tick) && !eom_set) begin
            pos_d   = pos_inc;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Shadow window fills as data returns; only COMMIT exposes it.
  always_comb begin
    shadow_d = shadow_q;
    if (cap_valid) begin
      shadow_d[(int'(cap_row)*LANES + int'(cap_lane))*CELL_W +: CELL_W] =
        cap_zero ? '0 : map_state;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pos_q    <= '0;
      pend_q   <= 1'b0;
      eom_q    <= 1'b0;
      ovr_q    <= 1'b0;
      vv_q     <= 1'b0;
      hit_q    <= 1'b0;
      coin_q   <= 1'b0;
      drain_q  <= '0;
      view_q   <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      pend_q   <= pend_d;
      eom_q    <= eom_d;
      ovr_q    <= ovr_d;
      vv_q     <= vv_d;
      hit_q    <= hit_d;
      coin_q   <= coin_d;
      drain_q  <= drain_d;
      view_q   <= view_d;
      shadow_q <= shadow_d;
    end
  end

  assign view_cells = view_q;
  assign pos        = pos_q;
  assign busy       = (state_q != ST_IDLE);
  assign view_valid = vv_q;
  assign hit        = hit_q;
  assign coin       = coin_q;
  assign end_of_map = eom_q;
  assign overrun    = ovr_q;
  assign dbg_state  = state_q;

endmodule
